pe_db: RTL and testbench
========================

PE_DB -- requirements
Module: pe_db

Interface
REQ-001 Parameter DATA_W, default 8: activation and weight width in bits.
REQ-002 Parameter ACC_W, default 32: partial-sum and accumulator width, ACC_W >= 2*DATA_W+1.
REQ-003 Parameter MAC_LAT, default 1: multiply-add latency in cycles, legal range 1..4.
REQ-004 Parameter ACT_DLY, default 3: extra activation forward delay, legal range 0..7.
REQ-005 Parameter SAT_EN, default 1: 1 = saturate results, 0 = wrap modulo 2^ACC_W.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 mode  in  1  0 = weight-stationary pass-down, 1 = output-stationary local accumulate.
REQ-009 sgn  in  1  1 = operands two's-complement, 0 = unsigned.
REQ-010 w_load  in  1  capture in_up_weight into the shadow weight.
REQ-011 w_swap  in  1  copy shadow weight into the active weight.
REQ-012 in_up_weight  in  DATA_W; out_down_weight  out  DATA_W  weight load chain.
REQ-013 in_left_act  in  DATA_W; in_left_vld  in  1  activation input.
REQ-014 out_right_act  out  DATA_W; out_right_vld  out  1  activation forward.
REQ-015 in_up_psum  in  ACC_W; in_up_psum_vld  in  1  upstream partial sum.
REQ-016 out_down_psum  out  ACC_W; out_down_psum_vld  out  1  downstream partial sum.
REQ-017 acc_clr  in  1; drain  in  1  OS-mode accumulator clear and drain.
REQ-018 ovf  out  1  sticky saturation/overflow flag.

Function
REQ-019 w_load=1: shadow <= in_up_weight; out_down_weight <= in_up_weight next cycle; w_load=0: out_down_weight <= 0.
REQ-020 w_swap=1: active <= shadow value held before this edge, so w_load and w_swap in the same cycle swap in the old shadow.
REQ-021 Each issued product uses the active weight sampled at issue; a swap never alters products already in flight.
REQ-022 out_right_act/out_right_vld = in_left_act/in_left_vld delayed ACT_DLY+1 cycles; out_right_act = 0 whenever out_right_vld = 0.
REQ-023 Product = in_left_act * active, signed or unsigned per sgn sampled at issue, extended to ACC_W.
REQ-024 WS mode: out_down_psum = product + (in_up_psum_vld ? in_up_psum : 0); out_down_psum_vld = in_left_vld; both appear MAC_LAT cycles after issue.
REQ-025 In WS mode, in_up_psum_vld=1 with in_left_vld=0 passes in_up_psum through with MAC_LAT latency and vld=1.
REQ-026 SAT_EN=1: results clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] when sgn=1, or [0, 2^ACC_W-1] when sgn=0; SAT_EN=0: results wrap modulo 2^ACC_W.
REQ-027 ovf is set on any clamp (SAT_EN=1) or wrap (SAT_EN=0); it clears only on acc_clr or reset.
REQ-028 OS mode: each valid product, at its MAC_LAT completion, is added into the local accumulator with REQ-026 rules.
REQ-029 acc_clr clears the accumulator; if a product completes in the same cycle, the accumulator becomes that product (clear then add).
REQ-030 OS drain=1: out_down_psum <= accumulator next cycle with vld=1 for one cycle; the accumulator is not cleared.
REQ-031 OS mode, drain=0, in_up_psum_vld=1: in_up_psum is forwarded with 1-cycle latency and vld=1, forming the drain chain.
REQ-032 drain and in_up_psum_vld asserted in the same cycle: the local accumulator wins and the upstream value is dropped.
REQ-033 mode and sgn stay static while any product is in flight; a change with a product in flight gives undefined results.

Reset
REQ-034 While rst_n=0, asynchronously: shadow, active, accumulator, all delay and pipeline stages, every output and ovf go to 0.
REQ-035 Assertion mid-operation discards all in-flight data; no vld output asserts until new input arrives after rst_n rises.

Verification
REQ-036 Weight chain: w_load with weight 5 then w_swap, act 3, WS mode, psum 10 vld -> out_down_psum 25, vld exactly MAC_LAT cycles later.
REQ-037 Double-buffer: active 2, w_load 7 during an act stream of 1s -> outputs stay 2 until w_swap, then 7 from the first product issued after the swap.
REQ-038 Signed saturation: sgn=1, ACC_W=16, act -128, weight -128, psum 32767 -> out_down_psum 32767, ovf=1; with SAT_EN=0 -> wrapped value, ovf=1.
REQ-039 OS accumulate: acc_clr, then acts 1,2,3 with weight 4, then drain -> out_down_psum 24 with a 1-cycle vld pulse; drain together with upstream vld -> output 24.
REQ-040 Activation forward: ACT_DLY=3, pulse act 0x5A with vld -> out_right_act 0x5A exactly 4 cycles later, 0 elsewhere.
REQ-041 Reset: drop rst_n with MAC_LAT=4 products in flight -> outputs 0 immediately, no vld after release.

Source files
------------

// File: rtl/pe_db_if.sv
// pe_db port bundle: controls, weight chain,
// activation forward and partial-sum buses.
interface pe_db_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
);
  logic              mode;
  logic              sgn;
  logic              w_load;
  logic              w_swap;
  logic [DATA_W-1:0] in_up_weight;
  logic [DATA_W-1:0] out_down_weight;
  logic [DATA_W-1:0] in_left_act;
  logic              in_left_vld;
  logic [DATA_W-1:0] out_right_act;
  logic              out_right_vld;
  logic [ACC_W-1:0]  in_up_psum;
  logic              in_up_psum_vld;
  logic [ACC_W-1:0]  out_down_psum;
  logic              out_down_psum_vld;
  logic              acc_clr;
  logic              drain;
  logic              ovf;

  modport master (
    output mode, sgn, w_load, w_swap,
    output in_up_weight, in_left_act, in_left_vld,
    output in_up_psum, in_up_psum_vld,
    output acc_clr, drain,
    input  out_down_weight, out_right_act,
    input  out_right_vld, out_down_psum,
    input  out_down_psum_vld, ovf
  );

  modport slave (
    input  mode, sgn, w_load, w_swap,
    input  in_up_weight, in_left_act, in_left_vld,
    input  in_up_psum, in_up_psum_vld,
    input  acc_clr, drain,
    output out_down_weight, out_right_act,
    output out_right_vld, out_down_psum,
    output out_down_psum_vld, ovf
  );
endinterface

// File: rtl/pe_db.sv
// Double-buffered-weight systolic PE: WS pass-down
// or OS local accumulate, with saturate/wrap.
module pe_db #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32,
  parameter int MAC_LAT = 1,
  parameter int ACT_DLY = 3,
  parameter bit SAT_EN  = 1'b1
) (
  input logic   clk,
  input logic   rst_n,
  pe_db_if.slave io
);
  localparam int X  = ACC_W + 2;
  localparam int PW = 2*DATA_W + 2;
  localparam int BW = ACC_W + 2;

  logic [DATA_W-1:0] shadow_q, active_q, wdn_q;
  logic [ACC_W-1:0]  acc_q, psum_q;
  logic              pvld_q, ovf_q;
  logic [DATA_W:0]   ad_q [ACT_DLY+1];

  function automatic logic signed [X-1:0] ext(
    input logic [ACC_W-1:0] v, input logic sg);
    return {{2{sg & v[ACC_W-1]}}, v};
  endfunction

  // Returns {out_of_range, clamped-or-wrapped value}.
  function automatic logic [ACC_W:0] fix(
    input logic signed [X-1:0] s, input logic sg);
    logic hi, lo;
    logic [ACC_W-1:0] v;
    if (sg) begin
      hi = !s[X-1] && (s[X-2:ACC_W-1] != '0);
      lo =  s[X-1] && (s[X-2:ACC_W-1] != '1);
    end else begin
      hi = !s[X-1] && s[ACC_W];
      lo =  s[X-1];
    end
    v = s[ACC_W-1:0];
    if (SAT_EN && hi)
      v = sg ? {1'b0, {(ACC_W-1){1'b1}}} : '1;
    else if (SAT_EN && lo)
      v = sg ? {1'b1, {(ACC_W-1){1'b0}}} : '0;
    return {hi | lo, v};
  endfunction

  logic signed [PW-1:0] a_x, w_x, prod_n;
  logic signed [X-1:0]  p_x, u_x;
  logic [ACC_W:0]       ws_fix, acc_d;
  logic [BW-1:0]        iss, cmp;
  logic                 c_vld, c_ovf;
  logic [ACC_W-1:0]     c_val;

  assign a_x = {{(DATA_W+2){io.sgn & io.in_left_act[DATA_W-1]}},
                io.in_left_act};
  assign w_x = {{(DATA_W+2){io.sgn & active_q[DATA_W-1]}},
                active_q};
  assign prod_n = a_x * w_x;
  assign p_x = io.in_left_vld ?
    {{(X-PW){prod_n[PW-1]}}, prod_n} : '0;
  assign u_x = io.in_up_psum_vld ?
    ext(io.in_up_psum, io.sgn) : '0;
  assign ws_fix = fix(p_x + u_x, io.sgn);

  // WS finishes the sum at issue; OS carries the bare product.
  assign iss = {
    io.in_left_vld | (!io.mode & io.in_up_psum_vld),
    !io.mode & ws_fix[ACC_W],
    io.mode ? p_x[ACC_W-1:0] : ws_fix[ACC_W-1:0]
  };

  if (MAC_LAT == 1) begin : g_l1
    assign cmp = iss;
  end else begin : g_ln
    logic [BW-1:0] pv_q [MAC_LAT-1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < MAC_LAT-1; i++) pv_q[i] <= '0;
      end else begin
        pv_q[0] <= iss;
        for (int i = 1; i < MAC_LAT-1; i++)
          pv_q[i] <= pv_q[i-1];
      end
    end
    assign cmp = pv_q[MAC_LAT-2];
  end

  assign {c_vld, c_ovf, c_val} = cmp;
  assign acc_d = fix(
    (io.acc_clr ? '0 : ext(acc_q, io.sgn)) +
    {{2{c_val[ACC_W-1]}}, c_val}, io.sgn);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= ACT_DLY; i++) ad_q[i] <= '0;
    end else begin
      ad_q[0] <= {io.in_left_vld,
                  io.in_left_act & {DATA_W{io.in_left_vld}}};
      for (int i = 1; i <= ACT_DLY; i++) ad_q[i] <= ad_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      wdn_q    <= '0;
      acc_q    <= '0;
      psum_q   <= '0;
      pvld_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (io.w_load) shadow_q <= io.in_up_weight;
      if (io.w_swap) active_q <= shadow_q;
      wdn_q <= io.w_load ? io.in_up_weight : '0;
      if (io.mode && c_vld) acc_q <= acc_d[ACC_W-1:0];
      else if (io.acc_clr)  acc_q <= '0;
      ovf_q <= (ovf_q & !io.acc_clr) |
               (c_vld & (io.mode ? acc_d[ACC_W] : c_ovf));
      if (!io.mode) begin
        psum_q <= c_vld ? c_val : '0;
        pvld_q <= c_vld;
      end else if (io.drain) begin
        psum_q <= acc_q;
        pvld_q <= 1'b1;
      end else if (io.in_up_psum_vld) begin
        psum_q <= io.in_up_psum;
        pvld_q <= 1'b1;
      end else begin
        psum_q <= '0;
        pvld_q <= 1'b0;
      end
    end
  end

  assign io.out_down_weight   = wdn_q;
  assign io.out_right_vld     = ad_q[ACT_DLY][DATA_W];
  assign io.out_right_act     = ad_q[ACT_DLY][DATA_W-1:0];
  assign io.out_down_psum     = psum_q;
  assign io.out_down_psum_vld = pvld_q;
  assign io.ovf               = ovf_q;
endmodule

// File: tb/tb_pe_db.sv
// Directed bench for pe_db: three instances with
// different ACC_W / MAC_LAT / ACT_DLY / SAT_EN.
module tb_pe_db;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        mode, sgn, w_load, w_swap, act_vld;
  logic        psum_vld, acc_clr, drain;
  logic [7:0]  wt, act;
  logic [31:0] psum;
  int n_tests = 0;
  int n_fail  = 0;

  pe_db_if #(.DATA_W(8), .ACC_W(32)) ia ();
  pe_db_if #(.DATA_W(8), .ACC_W(16)) ib ();
  pe_db_if #(.DATA_W(8), .ACC_W(16)) ic ();

  assign ia.mode = mode;  assign ib.mode = mode;  assign ic.mode = mode;
  assign ia.sgn = sgn;    assign ib.sgn = sgn;    assign ic.sgn = sgn;
  assign ia.w_load = w_load; assign ib.w_load = w_load; assign ic.w_load = w_load;
  assign ia.w_swap = w_swap; assign ib.w_swap = w_swap; assign ic.w_swap = w_swap;
  assign ia.in_up_weight = wt; assign ib.in_up_weight = wt; assign ic.in_up_weight = wt;
  assign ia.in_left_act = act; assign ib.in_left_act = act; assign ic.in_left_act = act;
  assign ia.in_left_vld = act_vld; assign ib.in_left_vld = act_vld; assign ic.in_left_vld = act_vld;
  assign ia.in_up_psum = psum; assign ib.in_up_psum = psum[15:0]; assign ic.in_up_psum = psum[15:0];
  assign ia.in_up_psum_vld = psum_vld; assign ib.in_up_psum_vld = psum_vld; assign ic.in_up_psum_vld = psum_vld;
  assign ia.acc_clr = acc_clr; assign ib.acc_clr = acc_clr; assign ic.acc_clr = acc_clr;
  assign ia.drain = drain; assign ib.drain = drain; assign ic.drain = drain;

  pe_db #(.DATA_W(8), .ACC_W(32), .MAC_LAT(1), .ACT_DLY(3), .SAT_EN(1'b1))
    u_a (.clk(clk), .rst_n(rst_n), .io(ia));
  pe_db #(.DATA_W(8), .ACC_W(16), .MAC_LAT(2), .ACT_DLY(0), .SAT_EN(1'b1))
    u_b (.clk(clk), .rst_n(rst_n), .io(ib));
  pe_db #(.DATA_W(8), .ACC_W(16), .MAC_LAT(4), .ACT_DLY(3), .SAT_EN(1'b0))
    u_c (.clk(clk), .rst_n(rst_n), .io(ic));

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic idle();
    w_load = 0; w_swap = 0; wt = 0; act = 0; act_vld = 0;
    psum = 0; psum_vld = 0; acc_clr = 0; drain = 0;
  endtask

  task automatic load_w(input logic [7:0] w);
    w_load = 1; wt = w; tick();
    w_load = 0; wt = 0; w_swap = 1; tick();
    w_swap = 0;
  endtask

  task automatic test_reset();
    n_tests++; if (ia.out_down_psum !== 32'd0 || ia.out_down_psum_vld !== 1'b0) begin
      $display("FAIL rst_psum: got %0h/%0b want 0/0", ia.out_down_psum, ia.out_down_psum_vld); n_fail++; end
    n_tests++; if (ia.out_right_act !== 8'd0 || ia.out_right_vld !== 1'b0) begin
      $display("FAIL rst_act: got %0h/%0b want 0/0", ia.out_right_act, ia.out_right_vld); n_fail++; end
    n_tests++; if (ia.ovf !== 1'b0 || ic.ovf !== 1'b0 || ia.out_down_weight !== 8'd0) begin
      $display("FAIL rst_misc: got ovf %0b/%0b wdn %0h want 0", ia.ovf, ic.ovf, ia.out_down_weight); n_fail++; end
  endtask

  task automatic test_weight_chain();
    mode = 0; sgn = 0;
    w_load = 1; wt = 8'd5; tick();
    n_tests++; if (ia.out_down_weight !== 8'd5) begin
      $display("FAIL wc_wdn_load: got %0d want 5", ia.out_down_weight); n_fail++; end
    w_load = 0; wt = 0; w_swap = 1; tick();
    n_tests++; if (ia.out_down_weight !== 8'd0) begin
      $display("FAIL wc_wdn_idle: got %0d want 0", ia.out_down_weight); n_fail++; end
    w_swap = 0; act = 8'd3; act_vld = 1; psum = 32'd10; psum_vld = 1; tick();
    idle();
    for (int k = 1; k <= 4; k++) begin
      n_tests++; if (ia.out_down_psum_vld !== (k == 1) || (k == 1 && ia.out_down_psum !== 32'd25)) begin
        $display("FAIL wc_lat1 k=%0d: got %0d/%0b want 25 vld=%0b", k, ia.out_down_psum, ia.out_down_psum_vld, k == 1); n_fail++; end
      n_tests++; if (ib.out_down_psum_vld !== (k == 2) || (k == 2 && ib.out_down_psum !== 16'd25)) begin
        $display("FAIL wc_lat2 k=%0d: got %0d/%0b want 25 vld=%0b", k, ib.out_down_psum, ib.out_down_psum_vld, k == 2); n_fail++; end
      n_tests++; if (ic.out_down_psum_vld !== (k == 4) || (k == 4 && ic.out_down_psum !== 16'd25)) begin
        $display("FAIL wc_lat4 k=%0d: got %0d/%0b want 25 vld=%0b", k, ic.out_down_psum, ic.out_down_psum_vld, k == 4); n_fail++; end
      tick();
    end
  endtask

  task automatic test_double_buffer();
    logic [7:0] exp_a [8];
    logic [7:0] ld    [8];
    logic       sw    [8];
    exp_a = '{8'd2, 8'd2, 8'd2, 8'd7, 8'd7, 8'd7, 8'd7, 8'd9};
    ld    = '{8'd7, 8'd0, 8'd0, 8'd0, 8'd9, 8'd0, 8'd0, 8'd0};
    sw    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    mode = 0; sgn = 0; idle(); load_w(8'd2);
    for (int i = 0; i < 8; i++) begin
      act = 8'd1; act_vld = 1;
      w_load = (ld[i] != 0); wt = ld[i]; w_swap = sw[i];
      tick();
      n_tests++; if (ia.out_down_psum !== {24'd0, exp_a[i]}) begin
        $display("FAIL db_out i=%0d: got %0d want %0d", i, ia.out_down_psum, exp_a[i]); n_fail++; end
      if (i == 5) begin
        n_tests++; if (ic.out_down_psum !== 16'd2) begin
          $display("FAIL db_inflight: got %0d want 2", ic.out_down_psum); n_fail++; end
      end
    end
    idle(); repeat (5) tick();
  endtask

  task automatic test_saturation();
    mode = 0; sgn = 1; load_w(8'h80);
    act = 8'h80; act_vld = 1; psum = 32'h7FFF; psum_vld = 1; tick();
    idle();
    n_tests++; if (ia.out_down_psum !== 32'd49151 || ia.ovf !== 1'b0) begin
      $display("FAIL sat_wide: got %0d ovf %0b want 49151 ovf 0", ia.out_down_psum, ia.ovf); n_fail++; end
    tick();
    n_tests++; if (ib.out_down_psum !== 16'h7FFF || ib.ovf !== 1'b1) begin
      $display("FAIL sat_clamp: got %0h ovf %0b want 7fff ovf 1", ib.out_down_psum, ib.ovf); n_fail++; end
    tick(); tick();
    n_tests++; if (ic.out_down_psum !== 16'hBFFF || ic.ovf !== 1'b1) begin
      $display("FAIL sat_wrap: got %0h ovf %0b want bfff ovf 1", ic.out_down_psum, ic.ovf); n_fail++; end
    repeat (2) tick();
    n_tests++; if (ib.ovf !== 1'b1) begin
      $display("FAIL sat_sticky: got %0b want 1", ib.ovf); n_fail++; end
    acc_clr = 1; tick(); acc_clr = 0;
    n_tests++; if (ib.ovf !== 1'b0 || ic.ovf !== 1'b0) begin
      $display("FAIL sat_clr: got %0b/%0b want 0/0", ib.ovf, ic.ovf); n_fail++; end
    sgn = 0;
    act = 8'hFF; act_vld = 1; psum = 32'hFFFF; psum_vld = 1; tick();
    idle();
    n_tests++; if (ia.out_down_psum !== 32'h17F7F) begin
      $display("FAIL usat_wide: got %0h want 17f7f", ia.out_down_psum); n_fail++; end
    tick();
    n_tests++; if (ib.out_down_psum !== 16'hFFFF || ib.ovf !== 1'b1) begin
      $display("FAIL usat_clamp: got %0h ovf %0b want ffff ovf 1", ib.out_down_psum, ib.ovf); n_fail++; end
    tick(); tick();
    n_tests++; if (ic.out_down_psum !== 16'h7F7F || ic.ovf !== 1'b1) begin
      $display("FAIL usat_wrap: got %0h ovf %0b want 7f7f ovf 1", ic.out_down_psum, ic.ovf); n_fail++; end
    acc_clr = 1; tick(); acc_clr = 0; repeat (2) tick();
  endtask

  task automatic test_os_accumulate();
    mode = 1; sgn = 0; load_w(8'd4);
    acc_clr = 1; tick(); acc_clr = 0;
    for (int i = 1; i <= 3; i++) begin
      act = 8'(i); act_vld = 1; tick();
      n_tests++; if (ia.out_down_psum_vld !== 1'b0) begin
        $display("FAIL os_novld i=%0d: got %0b want 0", i, ia.out_down_psum_vld); n_fail++; end
    end
    idle(); repeat (4) tick();
    drain = 1; tick(); drain = 0;
    n_tests++; if (ia.out_down_psum !== 32'd24 || ia.out_down_psum_vld !== 1'b1) begin
      $display("FAIL os_drain_a: got %0d/%0b want 24/1", ia.out_down_psum, ia.out_down_psum_vld); n_fail++; end
    n_tests++; if (ic.out_down_psum !== 16'd24 || ic.out_down_psum_vld !== 1'b1) begin
      $display("FAIL os_drain_c: got %0d/%0b want 24/1", ic.out_down_psum, ic.out_down_psum_vld); n_fail++; end
    tick();
    n_tests++; if (ia.out_down_psum_vld !== 1'b0) begin
      $display("FAIL os_pulse: got %0b want 0", ia.out_down_psum_vld); n_fail++; end
    drain = 1; psum = 32'd77; psum_vld = 1; tick(); drain = 0;
    n_tests++; if (ia.out_down_psum !== 32'd24 || ia.out_down_psum_vld !== 1'b1) begin
      $display("FAIL os_drain_wins: got %0d/%0b want 24/1", ia.out_down_psum, ia.out_down_psum_vld); n_fail++; end
    tick(); psum_vld = 0; psum = 0;
    n_tests++; if (ia.out_down_psum !== 32'd77 || ia.out_down_psum_vld !== 1'b1) begin
      $display("FAIL os_fwd: got %0d/%0b want 77/1", ia.out_down_psum, ia.out_down_psum_vld); n_fail++; end
    acc_clr = 1; act = 8'd5; act_vld = 1; tick();
    idle(); repeat (4) tick();
    drain = 1; tick(); drain = 0;
    n_tests++; if (ia.out_down_psum !== 32'd20 || ic.out_down_psum !== 16'd20) begin
      $display("FAIL os_clr_add: got %0d/%0d want 20/20", ia.out_down_psum, ic.out_down_psum); n_fail++; end
    repeat (2) tick();
  endtask

  task automatic test_act_forward();
    act = 8'h5A; act_vld = 1; tick();
    act = 8'h33; act_vld = 0;
    n_tests++; if (ib.out_right_act !== 8'h5A || ib.out_right_vld !== 1'b1) begin
      $display("FAIL af_dly0: got %0h/%0b want 5a/1", ib.out_right_act, ib.out_right_vld); n_fail++; end
    for (int k = 1; k <= 6; k++) begin
      n_tests++; if (ia.out_right_act !== ((k == 4) ? 8'h5A : 8'h00) || ia.out_right_vld !== (k == 4)) begin
        $display("FAIL af_dly3 k=%0d: got %0h/%0b want %0h/%0b", k, ia.out_right_act, ia.out_right_vld, (k == 4) ? 8'h5A : 8'h00, k == 4); n_fail++; end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_inflight();
    mode = 0; sgn = 0;
    for (int i = 1; i <= 4; i++) begin
      act = 8'(i); act_vld = 1; tick();
    end
    n_tests++; if (ic.out_down_psum !== 16'd4 || ic.out_down_psum_vld !== 1'b1) begin
      $display("FAIL rf_pre: got %0d/%0b want 4/1", ic.out_down_psum, ic.out_down_psum_vld); n_fail++; end
    #2 rst_n = 0; #1;
    n_tests++; if (ic.out_down_psum !== 16'd0 || ic.out_down_psum_vld !== 1'b0 || ic.out_right_vld !== 1'b0) begin
      $display("FAIL rf_async: got %0d/%0b/%0b want 0/0/0", ic.out_down_psum, ic.out_down_psum_vld, ic.out_right_vld); n_fail++; end
    idle(); #2 rst_n = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_tests++; if (ic.out_down_psum_vld !== 1'b0 || ia.out_down_psum_vld !== 1'b0 || ic.out_right_vld !== 1'b0) begin
        $display("FAIL rf_post k=%0d: got vld %0b/%0b/%0b want 0", k, ic.out_down_psum_vld, ia.out_down_psum_vld, ic.out_right_vld); n_fail++; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mode = 0; sgn = 0; idle();
    #1 test_reset();
    #20 rst_n = 1;
    test_weight_chain();
    test_double_buffer();
    test_saturation();
    test_os_accumulate();
    test_act_forward();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
